// File: rtl/riskv_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter unit.
package riskv_pkg;

    // Next-PC source select driven by decode/execute control.
    typedef enum logic [2:0] {
        PC_INC    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JALR   = 3'd2,
        PC_TRAP   = 3'd3,
        PC_MRET   = 3'd4
    } pc_sel_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'hBFC0_0380;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidate generator: sequential, branch and JALR targets.
// Build option MISALIGN_TRAP_EN: when defined, redirect targets are passed through
// unmodified and misalignment is flagged; when undefined, targets are word-aligned
// by clearing bits [1:0] and the flags are constant 0.
module pc_target_calc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] rs1,
    output logic [DATA_WIDTH-1:0] inc_target,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] jalr_target,
    output logic                  branch_misaligned,
    output logic                  jalr_misaligned
);

    logic [DATA_WIDTH-1:0] branch_raw;
    logic [DATA_WIDTH-1:0] jalr_raw;

    // All additions wrap modulo 2^DATA_WIDTH; carries out are intentionally dropped.
    assign inc_target = pc + DATA_WIDTH'(4);
    assign branch_raw = pc + imm;
    assign jalr_raw   = (rs1 + imm) & ~DATA_WIDTH'(1);

`ifdef MISALIGN_TRAP_EN
    assign branch_target     = branch_raw;
    assign jalr_target       = jalr_raw;
    assign branch_misaligned = (branch_raw[1:0] != 2'b00);
    assign jalr_misaligned   = (jalr_raw[1:0] != 2'b00);
`else
    assign branch_target     = branch_raw & ~DATA_WIDTH'(3);
    assign jalr_target       = jalr_raw & ~DATA_WIDTH'(3);
    assign branch_misaligned = 1'b0;
    assign jalr_misaligned   = 1'b0;
`endif

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds PC, selects the next PC, raises a one-cycle
// flush after any redirect and captures the exception PC on trap.
// Build option MISALIGN_TRAP_EN (see pc_target_calc): misaligned branch/JALR
// targets turn into a trap that also pulses 'misaligned'.
module pc_unit
    import riskv_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  pc_sel_t               PCsrc,
    input  logic [DATA_WIDTH-1:0] immOp,
    input  logic [DATA_WIDTH-1:0] rs1,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCplus4,
    output logic [DATA_WIDTH-1:0] epc,
    output logic                  flush,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] inc_target;
    logic [DATA_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] jalr_target;
    logic                  branch_misaligned;
    logic                  jalr_misaligned;

    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] epc_next;
    logic                  flush_next;
    logic                  misaligned_next;

    pc_target_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_target_calc (
        .pc               (PC),
        .imm              (immOp),
        .rs1              (rs1),
        .inc_target       (inc_target),
        .branch_target    (branch_target),
        .jalr_target      (jalr_target),
        .branch_misaligned(branch_misaligned),
        .jalr_misaligned  (jalr_misaligned)
    );

    assign PCplus4 = inc_target;

    // Next-state select: redirects take priority over stall; unknown encodings act as PC_INC.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        pc_next         = PC;
        epc_next        = epc;
        flush_next      = 1'b0;
        misaligned_next = 1'b0;
        unique case (PCsrc)
            PC_TRAP: begin
                pc_next    = TRAP_VECTOR;
                epc_next   = PC;
                flush_next = 1'b1;
            end
            PC_MRET: begin
                pc_next    = epc;
                flush_next = 1'b1;
            end
            PC_BRANCH: begin
                flush_next = 1'b1;
                if (branch_misaligned) begin
                    pc_next         = TRAP_VECTOR;
                    epc_next        = PC;
                    misaligned_next = 1'b1;
                end else begin
                    pc_next = branch_target;
                end
            end
            PC_JALR: begin
                flush_next = 1'b1;
                if (jalr_misaligned) begin
                    pc_next         = TRAP_VECTOR;
                    epc_next        = PC;
                    misaligned_next = 1'b1;
                end else begin
                    pc_next = jalr_target;
                end
            end
            default: begin
                if (!stall) begin
                    pc_next = inc_target;
                end
            end
        endcase
    end

    // PC, EPC and status registers; reset acts asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC         <= RESET_VECTOR;
            epc        <= '0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            PC         <= pc_next;
            epc        <= epc_next;
            flush      <= flush_next;
            misaligned <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes hand-computed expectations per
// issued cycle, a monitor pops and compares one entry after each rising edge.
// Expectations for the MISALIGN_TRAP_EN build are selected with the same macro.
module tb_pc_unit;
    import riskv_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    pc_sel_t       PCsrc;
    logic [W-1:0]  immOp;
    logic [W-1:0]  rs1;
    logic [W-1:0]  PC;
    logic [W-1:0]  PCplus4;
    logic [W-1:0]  epc;
    logic          flush;
    logic          misaligned;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] pc;
        logic [W-1:0] epc;
        logic         flush;
        logic         mis;
    } exp_t;

    exp_t sb[$];

    pc_unit #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .immOp     (immOp),
        .rs1       (rs1),
        .PC        (PC),
        .PCplus4   (PCplus4),
        .epc       (epc),
        .flush     (flush),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at a falling edge and record what must appear after the next rising edge.
    task automatic step(input string name, input pc_sel_t src, input logic st,
                        input logic [W-1:0] imm, input logic [W-1:0] r1,
                        input logic [W-1:0] e_pc, input logic [W-1:0] e_epc,
                        input logic e_fl, input logic e_mis);
        exp_t e;
        PCsrc = src;
        stall = st;
        immOp = imm;
        rs1   = r1;
        e.name  = name;
        e.pc    = e_pc;
        e.epc   = e_epc;
        e.flush = e_fl;
        e.mis   = e_mis;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every rising edge with a pending expectation is compared shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".pc"}, PC, e.pc);
                check({e.name, ".pcplus4"}, PCplus4, e.pc + 32'd4);
                check({e.name, ".epc"}, epc, e.epc);
                check({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
                check({e.name, ".mis"}, {31'd0, misaligned}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b1;
        PCsrc = PC_INC;
        immOp = '0;
        rs1   = '0;
        #1;
        check("reset.pc", PC, 32'hBFC0_0000);
        check("reset.epc", epc, 32'h0);
        check("reset.flush", {31'd0, flush}, 32'd0);
        check("reset.mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step("first_inc", PC_INC, 1'b0, 32'd0, 32'd0, 32'hBFC0_0004, 32'h0, 1'b0, 1'b0);

        // Wrap-around of the sequential target.
        step("to_top",    PC_JALR, 1'b0, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
        step("wrap_inc",  PC_INC,  1'b0, 32'd0, 32'd0,         32'h0000_0000, 32'h0, 1'b0, 1'b0);

        // Stall holds PC for three cycles, then release.
        step("to_200",    PC_JALR, 1'b0, 32'd0, 32'h200, 32'h200, 32'h0, 1'b1, 1'b0);
        step("stall1",    PC_INC,  1'b1, 32'd0, 32'd0,   32'h200, 32'h0, 1'b0, 1'b0);
        step("stall2",    PC_INC,  1'b1, 32'd0, 32'd0,   32'h200, 32'h0, 1'b0, 1'b0);
        step("stall3",    PC_INC,  1'b1, 32'd0, 32'd0,   32'h200, 32'h0, 1'b0, 1'b0);
        step("release",   PC_INC,  1'b0, 32'd0, 32'd0,   32'h204, 32'h0, 1'b0, 1'b0);

        // Backward branch overrides stall; flush lasts exactly one cycle.
        step("to_100",    PC_JALR,   1'b0, 32'd0,         32'h100, 32'h100, 32'h0, 1'b1, 1'b0);
        step("br_stall",  PC_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'd0,   32'h0F8, 32'h0, 1'b1, 1'b0);
        step("after_br",  PC_INC,    1'b0, 32'd0,         32'd0,   32'h0FC, 32'h0, 1'b0, 1'b0);

        // Trap captures EPC, MRET returns to it.
        step("to_400",    PC_JALR, 1'b0, 32'd0, 32'h400, 32'h400,       32'h0,   1'b1, 1'b0);
        step("trap",      PC_TRAP, 1'b1, 32'd0, 32'd0,   32'hBFC0_0380, 32'h400, 1'b1, 1'b0);
        step("in_handler",PC_INC,  1'b0, 32'd0, 32'd0,   32'hBFC0_0384, 32'h400, 1'b0, 1'b0);
        step("mret",      PC_MRET, 1'b0, 32'd0, 32'd0,   32'h400,       32'h400, 1'b1, 1'b0);
        step("after_mret",PC_INC,  1'b0, 32'd0, 32'd0,   32'h404,       32'h400, 1'b0, 1'b0);

`ifdef MISALIGN_TRAP_EN
        step("jalr_mis",  PC_JALR,          1'b0, 32'd0, 32'h1003, 32'hBFC0_0380, 32'h404, 1'b1, 1'b1);
        step("mis_clear", PC_INC,           1'b0, 32'd0, 32'd0,    32'hBFC0_0384, 32'h404, 1'b0, 1'b0);
        step("undef_sel", pc_sel_t'(3'd7),  1'b0, 32'd0, 32'd0,    32'hBFC0_0388, 32'h404, 1'b0, 1'b0);
        step("br_mis",    PC_BRANCH,        1'b1, 32'd6, 32'd0,    32'hBFC0_0380, 32'hBFC0_0388, 1'b1, 1'b1);
`else
        step("jalr_mis",  PC_JALR,          1'b0, 32'd0, 32'h1003, 32'h1000, 32'h400, 1'b1, 1'b0);
        step("mis_clear", PC_INC,           1'b0, 32'd0, 32'd0,    32'h1004, 32'h400, 1'b0, 1'b0);
        step("undef_sel", pc_sel_t'(3'd7),  1'b0, 32'd0, 32'd0,    32'h1008, 32'h400, 1'b0, 1'b0);
        step("br_mis",    PC_BRANCH,        1'b1, 32'd6, 32'd0,    32'h100C, 32'h400, 1'b1, 1'b0);
`endif

        // Asynchronous reset between edges while flush is high: effect is immediate.
        rst = 1'b1;
        #1;
        check("midrst.pc", PC, 32'hBFC0_0000);
        check("midrst.epc", epc, 32'h0);
        check("midrst.flush", {31'd0, flush}, 32'd0);
        check("midrst.mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst",  PC_INC, 1'b0, 32'd0, 32'd0, 32'hBFC0_0004, 32'h0, 1'b0, 1'b0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
